// File: rtl/dither_fill_engine.sv
// Rectangle fill engine with dithering: quantises an 8-bit grey level to
// black/white per pixel (4x4 ordered threshold or row-to-row error
// diffusion) and writes each pixel as one byte over the de_* port.
module dither_fill_engine #(
    parameter int SCREEN_W  = 640,
    parameter int ADDR_W    = 18,
    parameter int ERR_W     = 9,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    output logic              ack,
    output logic              busy,
    input  logic [15:0]       r0,
    input  logic [15:0]       r1,
    input  logic [15:0]       r2,
    input  logic [15:0]       r3,
    input  logic [15:0]       r4,
    output logic              de_req,
    input  logic              de_ack,
    output logic [ADDR_W-1:0] de_addr,
    output logic [3:0]        de_nbyte,
    output logic              de_rnw,
    output logic [31:0]       de_w_data
);

    localparam int IDX_W = (SCREEN_W > 1) ? $clog2(SCREEN_W) : 1;
    localparam int V_W   = (ERR_W + 2 > 11) ? ERR_W + 2 : 11;
    localparam int BA_W  = ADDR_W + 2;

    localparam logic signed [V_W-1:0] V_MID   = V_W'(128);
    localparam logic signed [V_W-1:0] V_WHITE = V_W'(255);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_CALC,
        S_WRITE
    } state_t;

    state_t                   state_q, state_d;
    logic [15:0]              xs_q, xs_d, ys_q, ys_d, xe_q, xe_d, ye_q, ye_d;
    logic [7:0]               colour_q, colour_d;
    logic                     mode_q, mode_d;
    logic [15:0]              x_q, x_d, y_q, y_d;
    logic signed [ERR_W-1:0]  err_left_q, err_left_d;
    logic                     ack_q, ack_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [3:0]               nbyte_q, nbyte_d;
    logic [31:0]              wdata_q, wdata_d;

    // Error line buffer: one signed error per screen column.
    logic signed [ERR_W-1:0]  err_buf [SCREEN_W];
    logic                     buf_we;
    logic signed [ERR_W-1:0]  buf_wdata;
    logic signed [ERR_W-1:0]  buf_rd;

    // Pixel datapath
    logic [7:0]               threshold;
    logic                     ord_white;
    logic signed [V_W-1:0]    col_ext, err_ext, buf_ext, v, e;
    logic                     dif_white;
    logic                     pix_white;
    logic [BA_W-1:0]          byte_addr;

    // Bayer 4x4 ordered-dither matrix entry for (row, col).
    function automatic logic [3:0] bayer(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] b;
        case ({row, col})
            4'h0: b = 4'd0;   4'h1: b = 4'd8;   4'h2: b = 4'd2;   4'h3: b = 4'd10;
            4'h4: b = 4'd12;  4'h5: b = 4'd4;   4'h6: b = 4'd14;  4'h7: b = 4'd6;
            4'h8: b = 4'd3;   4'h9: b = 4'd11;  4'hA: b = 4'd1;   4'hB: b = 4'd9;
            4'hC: b = 4'd15;  4'hD: b = 4'd7;   4'hE: b = 4'd13;  default: b = 4'd5;
        endcase
        return b;
    endfunction

    assign buf_rd = err_buf[x_q[IDX_W-1:0]];

    // Quantise the current pixel in both modes and form its byte address.
    always_comb begin
        // NOTE: combinational logic uses blocking '=' so each line sees the value computed above it.
        threshold = {bayer(y_q[1:0], x_q[1:0]), 4'h8};
        ord_white = (colour_q >= threshold);
        col_ext   = V_W'(colour_q);
        err_ext   = V_W'(err_left_q);
        buf_ext   = V_W'(buf_rd);
        v         = col_ext + (err_ext >>> 1) + (buf_ext >>> 1);
        dif_white = (v >= V_MID);
        e         = dif_white ? (v - V_WHITE) : v;
        pix_white = mode_q ? dif_white : ord_white;
        byte_addr = BA_W'(BASE_ADDR) + BA_W'(x_q) + BA_W'(y_q) * BA_W'(SCREEN_W);
    end

    // Next-state and datapath update for the fill sequencer.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        xs_d       = xs_q;
        ys_d       = ys_q;
        xe_d       = xe_q;
        ye_d       = ye_q;
        colour_d   = colour_q;
        mode_d     = mode_q;
        x_d        = x_q;
        y_d        = y_q;
        err_left_d = err_left_q;
        ack_d      = 1'b0;
        addr_d     = addr_q;
        nbyte_d    = nbyte_q;
        wdata_d    = wdata_q;
        buf_we     = 1'b0;
        buf_wdata  = '0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    xs_d       = r0;
                    ys_d       = r1;
                    xe_d       = r2;
                    ye_d       = r3;
                    colour_d   = r4[7:0];
                    mode_d     = r4[8];
                    x_d        = r0;
                    y_d        = r1;
                    err_left_d = '0;
                    ack_d      = 1'b1;
                    state_d    = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if ((xe_q < xs_q) || (ye_q < ys_q)) begin
                    state_d = S_IDLE;
                end else begin
                    buf_we = 1'b1;
                    if (x_q == xe_q) begin
                        x_d        = xs_q;
                        err_left_d = '0;
                        state_d    = S_CALC;
                    end else begin
                        x_d = x_q + 16'd1;
                    end
                end
            end
            S_CALC: begin
                addr_d  = byte_addr[BA_W-1:2];
                nbyte_d = ~(4'b0001 << byte_addr[1:0]);
                wdata_d = pix_white ? 32'hFFFF_FFFF : 32'h0000_0000;
                if (mode_q) begin
                    buf_we     = 1'b1;
                    buf_wdata  = e[ERR_W-1:0];
                    err_left_d = e[ERR_W-1:0];
                end
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (de_ack) begin
                    if (x_q < xe_q) begin
                        x_d     = x_q + 16'd1;
                        state_d = S_CALC;
                    end else if (y_q < ye_q) begin
                        x_d        = xs_q;
                        y_d        = y_q + 16'd1;
                        err_left_d = '0;
                        state_d    = S_CALC;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking '<=' so all registers update together at the edge.
        if (rst) begin
            state_q    <= S_IDLE;
            xs_q       <= '0;
            ys_q       <= '0;
            xe_q       <= '0;
            ye_q       <= '0;
            colour_q   <= '0;
            mode_q     <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            err_left_q <= '0;
            ack_q      <= 1'b0;
            addr_q     <= '0;
            nbyte_q    <= 4'b1111;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            xs_q       <= xs_d;
            ys_q       <= ys_d;
            xe_q       <= xe_d;
            ye_q       <= ye_d;
            colour_q   <= colour_d;
            mode_q     <= mode_d;
            x_q        <= x_d;
            y_q        <= y_d;
            err_left_q <= err_left_d;
            ack_q      <= ack_d;
            addr_q     <= addr_d;
            nbyte_q    <= nbyte_d;
            wdata_q    <= wdata_d;
        end
    end

    // Error line-buffer write port.
    always_ff @(posedge clk) begin
        // NOTE: the line buffer is a RAM and is not reset; CLEAR zeroes the columns a command will read.
        if (buf_we) begin
            err_buf[x_q[IDX_W-1:0]] <= buf_wdata;
        end
    end

    assign ack       = ack_q;
    assign busy      = (state_q != S_IDLE);
    assign de_req    = (state_q == S_WRITE);
    assign de_addr   = addr_q;
    assign de_nbyte  = nbyte_q;
    assign de_rnw    = 1'b0;
    assign de_w_data = wdata_q;

endmodule

// File: tb/tb_dither_fill_engine.sv
// Directed self-checking bench for dither_fill_engine.
module tb_dither_fill_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        de_ack = 1'b0;
    logic [15:0] r0 = '0, r1 = '0, r2 = '0, r3 = '0, r4 = '0;
    logic        ack, busy, de_req, de_rnw;
    logic [17:0] de_addr;
    logic [3:0]  de_nbyte;
    logic [31:0] de_w_data;

    int checks = 0;
    int errors = 0;
    int req_cycles = 0;
    int req_mark;

    logic [31:0] wr_addr[$];
    logic [3:0]  wr_nbyte[$];
    logic [31:0] wr_data[$];

    dither_fill_engine #(
        .SCREEN_W (640),
        .ADDR_W   (18),
        .ERR_W    (9),
        .BASE_ADDR(0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .ack      (ack),
        .busy     (busy),
        .r0       (r0),
        .r1       (r1),
        .r2       (r2),
        .r3       (r3),
        .r4       (r4),
        .de_req   (de_req),
        .de_ack   (de_ack),
        .de_addr  (de_addr),
        .de_nbyte (de_nbyte),
        .de_rnw   (de_rnw),
        .de_w_data(de_w_data)
    );

    always #5 clk = ~clk;

    // Log every completed frame-store write, sampled mid-cycle.
    always @(negedge clk) begin
        if (de_req) req_cycles++;
        if (de_req && de_ack) begin
            wr_addr.push_back(32'(de_addr));
            wr_nbyte.push_back(de_nbyte);
            wr_data.push_back(de_w_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_nbyte.delete();
        wr_data.delete();
    endtask

    task automatic issue(input logic [15:0] xs, input logic [15:0] ys,
                         input logic [15:0] xe, input logic [15:0] ye,
                         input logic [7:0] colour, input logic mode);
        r0  = xs;
        r1  = ys;
        r2  = xe;
        r3  = ye;
        r4  = {7'd0, mode, colour};
        req = 1'b1;
        tick();
        check("ack_pulse", ack, 1);
        check("busy_start", busy, 1);
        req = 1'b0;
        tick();
        check("ack_drop", ack, 0);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check("idle_reached", busy, 0);
    endtask

    task automatic wait_de_req(input int budget);
        int n = 0;
        while (!de_req && n < budget) begin
            tick();
            n++;
        end
        check("de_req_reached", de_req, 1);
    endtask

    task automatic check_write(input int i, input logic [31:0] a,
                               input logic [3:0] nb, input logic [31:0] d);
        if (i < wr_addr.size()) begin
            check($sformatf("wr%0d_addr", i), wr_addr[i], a);
            check($sformatf("wr%0d_nbyte", i), 32'(wr_nbyte[i]), 32'(nb));
            check($sformatf("wr%0d_data", i), wr_data[i], d);
        end else begin
            check($sformatf("wr%0d_missing", i), wr_addr.size(), i + 1);
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_de_req", de_req, 0);
        check("rst_nbyte", 32'(de_nbyte), 32'hF);
        check("rst_wdata", de_w_data, 0);
        check("rst_rnw", de_rnw, 0);
        rst = 1'b0;
        tick();

        // Reset asserted mid-write drops everything asynchronously
        de_ack = 1'b0;
        clear_log();
        issue(0, 0, 3, 0, 8'h80, 1'b0);
        wait_de_req(20);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_de_req", de_req, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ack", ack, 0);
        check("midrst_nbyte", 32'(de_nbyte), 32'hF);
        tick();
        rst = 1'b0;
        tick();
        check("midrst_idle_de_req", de_req, 0);
        check("midrst_writes", wr_addr.size(), 0);

        // Ordered mode, one row of four, de_ack tied high
        de_ack = 1'b1;
        clear_log();
        issue(0, 0, 3, 0, 8'h80, 1'b0);
        wait_idle(60);
        check("ord_count", wr_addr.size(), 4);
        check_write(0, 0, 4'b1110, 32'hFFFF_FFFF);
        check_write(1, 0, 4'b1101, 32'h0000_0000);
        check_write(2, 0, 4'b1011, 32'hFFFF_FFFF);
        check_write(3, 0, 4'b0111, 32'h0000_0000);

        // Diffusion mode, same row: v = 128, 64, 160, 80
        clear_log();
        issue(0, 0, 3, 0, 8'h80, 1'b1);
        wait_idle(60);
        check("dif_count", wr_addr.size(), 4);
        check_write(0, 0, 4'b1110, 32'hFFFF_FFFF);
        check_write(1, 0, 4'b1101, 32'h0000_0000);
        check_write(2, 0, 4'b1011, 32'hFFFF_FFFF);
        check_write(3, 0, 4'b0111, 32'h0000_0000);

        // Diffusion 2x2: row1 sees buf = {-127, 64} -> v = 64, 192
        clear_log();
        issue(0, 0, 1, 1, 8'h80, 1'b1);
        wait_idle(60);
        check("dif2_count", wr_addr.size(), 4);
        check_write(0, 0,   4'b1110, 32'hFFFF_FFFF);
        check_write(1, 0,   4'b1101, 32'h0000_0000);
        check_write(2, 160, 4'b1110, 32'h0000_0000);
        check_write(3, 160, 4'b1101, 32'hFFFF_FFFF);

        // Diffusion single column (10,5)-(10,6): byte addrs 3210 and 3850
        clear_log();
        issue(10, 5, 10, 6, 8'h80, 1'b1);
        wait_idle(60);
        check("col_count", wr_addr.size(), 2);
        check_write(0, 802, 4'b1011, 32'hFFFF_FFFF);
        check_write(1, 962, 4'b1011, 32'h0000_0000);

        // Handshake stall at (2,2), ordered, colour 0x30 >= threshold 24
        de_ack = 1'b0;
        clear_log();
        issue(2, 2, 2, 2, 8'h30, 1'b0);
        wait_de_req(20);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) req = 1'b1;
            tick();
            check("stall_de_req", de_req, 1);
            check("stall_addr", 32'(de_addr), 320);
            check("stall_nbyte", 32'(de_nbyte), 32'hB);
            check("stall_data", de_w_data, 32'hFFFF_FFFF);
            if (i == 1) begin
                check("busy_req_no_ack", ack, 0);
                req = 1'b0;
            end
        end
        check("stall_no_write", wr_addr.size(), 0);
        de_ack = 1'b1;
        tick();
        de_ack = 1'b0;
        check("stall_done_busy", busy, 0);
        check("stall_done_de_req", de_req, 0);
        check("stall_count", wr_addr.size(), 1);
        check_write(0, 320, 4'b1011, 32'hFFFF_FFFF);
        tick();
        check("stall_late_ack", ack, 0);

        // Empty rectangles: ack, one busy cycle, no de_req
        clear_log();
        req_mark = req_cycles;
        issue(5, 0, 4, 0, 8'hFF, 1'b0);
        check("empty_x_busy", busy, 0);
        issue(0, 3, 0, 2, 8'hFF, 1'b1);
        check("empty_y_busy", busy, 0);
        tick();
        check("empty_de_req", req_cycles - req_mark, 0);
        check("empty_writes", wr_addr.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
